rtap_core_req_ctrl: RTL and testbench

RTAP_CORE_REQ_CTRL -- requirements
Module: rtap_core_req_ctrl

---
 rtl/rtap_core_req_ctrl_if.sv | 37 +++
 rtl/rtap_core_req_ctrl.sv | 113 +++++++++++
 tb/tb_rtap_core_req_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/rtap_core_req_ctrl_if.sv
// TAP-side request/response and core debug bus bundle for rtap_core_req_ctrl.
// slave = the controller, master = the TAP/core side driving it.
interface rtap_core_req_ctrl_if #(
  parameter int BUS_W = 128,
  parameter int ID_W  = 5
);
  logic             tap_req_val;
  logic             tap_req_rdy;
  logic [ID_W-1:0]  tap_req_core_id;
  logic [1:0]       tap_req_threadid;
  logic [BUS_W-1:0] tap_req_data;
  logic             rtap_core_val;
  logic [ID_W-1:0]  rtap_core_id;
  logic [1:0]       rtap_core_threadid;
  logic [BUS_W-1:0] rtap_core_data;
  logic [BUS_W-1:0] core_rtap_data;
  logic             tap_resp_val;
  logic [BUS_W-1:0] tap_resp_data;
  logic             tap_resp_ack;
  logic             tap_shift_en;
  logic             tap_tdo;
  logic             tap_shift_done;

  modport slave (
    input  tap_req_val, tap_req_core_id, tap_req_threadid, tap_req_data,
    input  core_rtap_data, tap_resp_ack, tap_shift_en,
    output tap_req_rdy, rtap_core_val, rtap_core_id, rtap_core_threadid, rtap_core_data,
    output tap_resp_val, tap_resp_data, tap_tdo, tap_shift_done
  );

  modport master (
    output tap_req_val, tap_req_core_id, tap_req_threadid, tap_req_data,
    output core_rtap_data, tap_resp_ack, tap_shift_en,
    input  tap_req_rdy, rtap_core_val, rtap_core_id, rtap_core_threadid, rtap_core_data,
    input  tap_resp_val, tap_resp_data, tap_tdo, tap_shift_done
  );
endinterface

// File: rtl/rtap_core_req_ctrl.sv
// Single-outstanding debug request controller: issues one strobe to the core,
// captures the response RESP_LAT cycles later and serialises it LSB first.
module rtap_core_req_ctrl #(
  parameter int BUS_W    = 128,
  parameter int ID_W     = 5,
  parameter int RESP_LAT = 1
) (
  input  logic                 rclk,
  input  logic                 rst_n,
  rtap_core_req_ctrl_if.slave  bus
);
  localparam int CNT_W = $clog2(BUS_W) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_e;

  state_e           state_q, state_d;
  logic             core_val_q, core_val_d;
  logic [ID_W-1:0]  core_id_q, core_id_d;
  logic [1:0]       core_th_q, core_th_d;
  logic [BUS_W-1:0] core_data_q, core_data_d;
  logic [2:0]       lat_cnt_q, lat_cnt_d;
  logic [BUS_W-1:0] cap_q, cap_d;
  logic [BUS_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             done_q, done_d;

  // Core-side outputs double as the request latch; they only live for ISSUE.
  always_comb begin
    state_d     = state_q;
    core_val_d  = 1'b0;
    core_id_d   = '0;
    core_th_d   = '0;
    core_data_d = '0;
    lat_cnt_d   = lat_cnt_q;
    cap_d       = cap_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: if (bus.tap_req_val) begin
        state_d     = ISSUE;
        core_val_d  = 1'b1;
        core_id_d   = bus.tap_req_core_id;
        core_th_d   = bus.tap_req_threadid;
        core_data_d = bus.tap_req_data;
      end
      ISSUE: begin
        state_d   = WAIT;
        lat_cnt_d = 3'(RESP_LAT);
      end
      WAIT: begin
        lat_cnt_d = lat_cnt_q - 3'd1;
        if (lat_cnt_q == 3'd1) begin
          cap_d     = bus.core_rtap_data;
          shift_d   = bus.core_rtap_data;
          bit_cnt_d = '0;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        // ack beats a simultaneous shift request
        if (bus.tap_resp_ack) begin
          state_d = IDLE;
        end else if (bus.tap_shift_en) begin
          shift_d   = {1'b0, shift_q[BUS_W-1:1]};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(BUS_W - 1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      core_val_q  <= 1'b0;
      core_id_q   <= '0;
      core_th_q   <= '0;
      core_data_q <= '0;
      lat_cnt_q   <= '0;
      cap_q       <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      core_val_q  <= core_val_d;
      core_id_q   <= core_id_d;
      core_th_q   <= core_th_d;
      core_data_q <= core_data_d;
      lat_cnt_q   <= lat_cnt_d;
      cap_q       <= cap_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      done_q      <= done_d;
    end
  end

  // rdy is gated by rst_n so it reads 0 while reset is held, even in IDLE.
  assign bus.tap_req_rdy        = rst_n & (state_q == IDLE);
  assign bus.rtap_core_val      = core_val_q;
  assign bus.rtap_core_id       = core_id_q;
  assign bus.rtap_core_threadid = core_th_q;
  assign bus.rtap_core_data     = core_data_q;
  assign bus.tap_resp_val       = (state_q == HOLD);
  assign bus.tap_resp_data      = (state_q == HOLD) ? cap_q : '0;
  assign bus.tap_tdo            = (state_q == HOLD) & shift_q[0];
  assign bus.tap_shift_done     = done_q;
endmodule

// File: tb/tb_rtap_core_req_ctrl.sv
// Directed bench for rtap_core_req_ctrl: one instance at RESP_LAT=1, one at RESP_LAT=4.
module tb_rtap_core_req_ctrl;
  localparam int BUS_W = 128;
  localparam int ID_W  = 5;

  logic rclk  = 1'b0;
  logic rst_n = 1'b0;
  always #5 rclk = ~rclk;

  rtap_core_req_ctrl_if #(.BUS_W(BUS_W), .ID_W(ID_W)) ia ();
  rtap_core_req_ctrl_if #(.BUS_W(BUS_W), .ID_W(ID_W)) ib ();

  rtap_core_req_ctrl #(.BUS_W(BUS_W), .ID_W(ID_W), .RESP_LAT(1)) ua (
    .rclk(rclk), .rst_n(rst_n), .bus(ia.slave));
  rtap_core_req_ctrl #(.BUS_W(BUS_W), .ID_W(ID_W), .RESP_LAT(4)) ub (
    .rclk(rclk), .rst_n(rst_n), .bus(ib.slave));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [BUS_W-1:0] got, input logic [BUS_W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  // Leaves ua in HOLD holding rsp.
  task automatic issue_a(input logic [ID_W-1:0] id, input logic [1:0] th,
                         input logic [BUS_W-1:0] d, input logic [BUS_W-1:0] rsp);
    ia.tap_req_core_id  = id;
    ia.tap_req_threadid = th;
    ia.tap_req_data     = d;
    ia.tap_req_val      = 1'b1;
    tick();
    ia.tap_req_val = 1'b0;
    chk("issue_strobe", ia.rtap_core_val, 1);
    tick();
    ia.core_rtap_data = rsp;
    tick();
    ia.core_rtap_data = '0;
    chk("issue_hold", ia.tap_resp_val, 1);
  endtask

  initial begin
    logic [BUS_W-1:0] v;
    int strobes;
    ia.tap_req_val = 0; ia.tap_req_core_id = '0; ia.tap_req_threadid = '0; ia.tap_req_data = '0;
    ia.core_rtap_data = '0; ia.tap_resp_ack = 0; ia.tap_shift_en = 0;
    ib.tap_req_val = 0; ib.tap_req_core_id = '0; ib.tap_req_threadid = '0; ib.tap_req_data = '0;
    ib.core_rtap_data = '0; ib.tap_resp_ack = 0; ib.tap_shift_en = 0;

    // reset state
    #3;
    chk("rst_rdy", ia.tap_req_rdy, 0);
    chk("rst_core_val", ia.rtap_core_val, 0);
    chk("rst_resp_val", ia.tap_resp_val, 0);
    chk("rst_tdo", ia.tap_tdo, 0);
    chk("rst_done", ia.tap_shift_done, 0);
    #9 rst_n = 1'b1;
    tick();
    chk("post_rst_rdy", ia.tap_req_rdy, 1);

    // basic request, RESP_LAT=1
    ia.tap_req_core_id = 5'd3; ia.tap_req_threadid = 2'd2; ia.tap_req_data = 128'hA5;
    ia.tap_req_val = 1'b1;
    tick();
    ia.tap_req_val = 1'b0;
    chk("t1_val", ia.rtap_core_val, 1);
    chk("t1_id", ia.rtap_core_id, 3);
    chk("t1_th", ia.rtap_core_threadid, 2);
    chk("t1_data", ia.rtap_core_data, 128'hA5);
    chk("t1_rdy_busy", ia.tap_req_rdy, 0);
    tick();
    chk("t1_wait_val", ia.rtap_core_val, 0);
    chk("t1_wait_id", ia.rtap_core_id, 0);
    chk("t1_wait_data", ia.rtap_core_data, 0);
    chk("t1_wait_resp", ia.tap_resp_val, 0);
    ia.core_rtap_data = 128'h1234;
    tick();
    ia.core_rtap_data = '0;
    chk("t1_resp_val", ia.tap_resp_val, 1);
    chk("t1_resp_data", ia.tap_resp_data, 128'h1234);
    chk("t1_tdo", ia.tap_tdo, 0);
    chk("t1_hold_rdy", ia.tap_req_rdy, 0);
    ia.tap_resp_ack = 1'b1;
    tick();
    ia.tap_resp_ack = 1'b0;
    chk("t1_ack_val", ia.tap_resp_val, 0);
    chk("t1_ack_rdy", ia.tap_req_rdy, 1);

    // full 128-bit shift of 0x5
    issue_a(5'd1, 2'd0, '0, 128'h5);
    v = 128'h5;
    chk("sh_tdo0", ia.tap_tdo, 1);
    ia.tap_shift_en = 1'b1;
    for (int i = 1; i <= BUS_W; i++) begin
      tick();
      if (i < BUS_W) begin
        chk("sh_tdo", ia.tap_tdo, v[i]);
        chk("sh_done_early", ia.tap_shift_done, 0);
      end else begin
        chk("sh_done", ia.tap_shift_done, 1);
        chk("sh_idle_val", ia.tap_resp_val, 0);
        chk("sh_idle_rdy", ia.tap_req_rdy, 1);
      end
    end
    ia.tap_shift_en = 1'b0;
    tick();
    chk("sh_done_once", ia.tap_shift_done, 0);
    chk("sh_rdy", ia.tap_req_rdy, 1);

    // ack wins over shift after 10 shifts
    issue_a(5'd2, 2'd1, '0, 128'h400);
    ia.tap_shift_en = 1'b1;
    repeat (10) tick();
    chk("ak_tdo10", ia.tap_tdo, 1);
    chk("ak_nodone", ia.tap_shift_done, 0);
    ia.tap_resp_ack = 1'b1;
    tick();
    ia.tap_resp_ack = 1'b0;
    ia.tap_shift_en = 1'b0;
    chk("ak_val", ia.tap_resp_val, 0);
    chk("ak_rdy", ia.tap_req_rdy, 1);
    chk("ak_done", ia.tap_shift_done, 0);
    chk("ak_tdo", ia.tap_tdo, 0);
    tick();
    chk("ak_done2", ia.tap_shift_done, 0);

    // req_val held high: one strobe per accepted request
    ia.tap_req_core_id = 5'd7; ia.tap_req_threadid = 2'd1; ia.tap_req_data = 128'h33;
    ia.tap_req_val = 1'b1;
    strobes = 0;
    repeat (6) begin
      tick();
      strobes += int'(ia.rtap_core_val);
    end
    chk("hv_strobes", 128'(strobes), 1);
    chk("hv_hold", ia.tap_resp_val, 1);
    ia.tap_resp_ack = 1'b1;
    tick();
    ia.tap_resp_ack = 1'b0;
    chk("hv_idle_val", ia.rtap_core_val, 0);
    chk("hv_idle_rdy", ia.tap_req_rdy, 1);
    tick();
    chk("hv_reaccept", ia.rtap_core_val, 1);
    ia.tap_req_val = 1'b0;
    tick();
    tick();
    chk("hv_hold2", ia.tap_resp_val, 1);
    ia.tap_resp_ack = 1'b1;
    tick();
    ia.tap_resp_ack = 1'b0;
    chk("hv_rdy2", ia.tap_req_rdy, 1);

    // async reset in WAIT drops the request
    ia.tap_req_core_id = 5'd4; ia.tap_req_threadid = 2'd3; ia.tap_req_data = 128'h99;
    ia.tap_req_val = 1'b1;
    tick();
    ia.tap_req_val = 1'b0;
    tick();
    ia.core_rtap_data = 128'hBEEF;
    #2 rst_n = 1'b0;
    #1;
    chk("rw_rdy", ia.tap_req_rdy, 0);
    chk("rw_core_val", ia.rtap_core_val, 0);
    chk("rw_resp_val", ia.tap_resp_val, 0);
    chk("rw_resp_data", ia.tap_resp_data, 0);
    chk("rw_tdo", ia.tap_tdo, 0);
    chk("rw_done", ia.tap_shift_done, 0);
    #1 rst_n = 1'b1;
    tick();
    chk("rw_rel_rdy", ia.tap_req_rdy, 1);
    chk("rw_no_cap", ia.tap_resp_val, 0);
    ia.core_rtap_data = '0;
    tick();
    chk("rw_no_cap2", ia.tap_resp_val, 0);
    issue_a(5'd1, 2'd1, 128'h1, 128'h77);
    chk("rw_after", ia.tap_resp_data, 128'h77);
    ia.tap_resp_ack = 1'b1;
    tick();
    ia.tap_resp_ack = 1'b0;

    // RESP_LAT=4: capture exactly 4 cycles after the strobe
    ib.tap_req_core_id = 5'd5; ib.tap_req_data = 128'h1; ib.tap_req_val = 1'b1;
    tick();
    ib.tap_req_val = 1'b0;
    chk("l4_strobe", ib.rtap_core_val, 1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      ib.core_rtap_data = (k == 4) ? 128'h4444 : ((k == 3 || k == 5) ? 128'hFF : 128'h0);
      if (k < 5) begin
        chk("l4_not_yet", ib.tap_resp_val, 0);
      end else begin
        chk("l4_val", ib.tap_resp_val, 1);
        chk("l4_data", ib.tap_resp_data, 128'h4444);
      end
    end
    tick();
    chk("l4_late_ignored", ib.tap_resp_data, 128'h4444);
    ib.core_rtap_data = '0;
    ib.tap_resp_ack = 1'b1;
    tick();
    ib.tap_resp_ack = 1'b0;
    chk("l4_rdy", ib.tap_req_rdy, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
